alarm_ctrl: RTL



---
 rtl/alarm_ctrl_pkg.sv | 21 ++
 rtl/alarm_ctrl_tick_gen.sv | 29 ++
 rtl/alarm_defs.vh | 13 +
 rtl/alarm_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - state type and widths for the alarm controller
package alarm_ctrl_pkg;

`include "alarm_defs.vh"

   localparam int CNT_W = `COUNTDOWN_W;

   typedef enum logic [2:0] {
      S_DISARMED    = `ST_DISARMED,
      S_EXIT_DELAY  = `ST_EXIT_DELAY,
      S_ARMED       = `ST_ARMED,
      S_ENTRY_DELAY = `ST_ENTRY_DELAY,
      S_ALARM       = `ST_ALARM
   } state_t;

   // Armed indicator covers the whole "system is live" span, including entry delay
   function automatic logic shows_armed(input state_t s);
      return (s == S_ARMED) || (s == S_ENTRY_DELAY);
   endfunction

endpackage

// File: rtl/alarm_ctrl_tick_gen.sv
// rtl/alarm_ctrl_tick_gen.sv - one-second prescaler with synchronous clear
module tick_gen #(
   parameter int TICK_CYCLES = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

   logic [CW-1:0] count;

   // Free-running 0..TICK_CYCLES-1; clr restarts the second so delays start on a clean boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/alarm_defs.vh
// rtl/alarm_defs.vh - state codes and countdown width shared with the display decoder
`ifndef ALARM_DEFS_VH
`define ALARM_DEFS_VH

`define ST_DISARMED    3'd0
`define ST_EXIT_DELAY  3'd1
`define ST_ARMED       3'd2
`define ST_ENTRY_DELAY 3'd3
`define ST_ALARM       3'd4

`define COUNTDOWN_W    8

`endif

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm state machine; optional SIREN_TIMEOUT_EN silences the siren after SIREN_SEC
module alarm_ctrl
   import alarm_ctrl_pkg::*;
#(
   parameter int TICK_CYCLES = 50000000,
   parameter int EXIT_SEC    = 10,
   parameter int ENTRY_SEC   = 5,
   parameter int N_ZONES     = 4,
   parameter int SIREN_SEC   = 30
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               armed_q,
   input  logic               panic_q,
   input  logic [N_ZONES-1:0] zone,
   output logic               siren,
   output logic               armed_led,
   output logic [CNT_W-1:0]   countdown,
   output logic [2:0]         state_out
);

`ifdef SIREN_TIMEOUT_EN
   localparam bit SIREN_TIMEOUT = 1'b1;
`else
   localparam bit SIREN_TIMEOUT = 1'b0;
`endif

   localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_SEC);
   localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_SEC);
   localparam logic [CNT_W-1:0] ALARM_LOAD = SIREN_TIMEOUT ? CNT_W'(SIREN_SEC) : '0;

   logic               arm_s1, arm_s2;
   logic               pan_s1, pan_s2;
   logic [N_ZONES-1:0] zone_s1, zone_s2;

   state_t             state, next_state;
   logic [CNT_W-1:0]   cnt, next_cnt;
   logic               tick;
   logic               expire;
   logic               state_chg;

   // Two-flop synchronisers for the latch outputs and zone switches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arm_s1  <= 1'b0;
         arm_s2  <= 1'b0;
         pan_s1  <= 1'b0;
         pan_s2  <= 1'b0;
         zone_s1 <= '0;
         zone_s2 <= '0;
      end else begin
         arm_s1  <= armed_q;
         arm_s2  <= arm_s1;
         pan_s1  <= panic_q;
         pan_s2  <= pan_s1;
         zone_s1 <= zone;
         zone_s2 <= zone_s1;
      end
   end

   tick_gen #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .clr (state_chg),
      .tick(tick)
   );

   // State and delay counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_DISARMED;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next state and counter: panic beats disarm beats sensor/timer in every state
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      // A zero load expires immediately; otherwise the last tick at 1 ends the delay
      expire     = (cnt == '0) || (tick && (cnt == CNT_W'(1)));

      case (state)
         S_DISARMED: begin
            if (pan_s2)      next_state = S_ALARM;
            else if (arm_s2) next_state = S_EXIT_DELAY;
         end
         S_EXIT_DELAY: begin
            if (pan_s2)       next_state = S_ALARM;
            else if (!arm_s2) next_state = S_DISARMED;
            else if (expire)  next_state = S_ARMED;
         end
         S_ARMED: begin
            if (pan_s2)         next_state = S_ALARM;
            else if (!arm_s2)   next_state = S_DISARMED;
            else if (|zone_s2)  next_state = S_ENTRY_DELAY;
         end
         S_ENTRY_DELAY: begin
            if (pan_s2)       next_state = S_ALARM;
            else if (!arm_s2) next_state = S_DISARMED;
            else if (expire)  next_state = S_ALARM;
         end
         S_ALARM: begin
            if (!arm_s2 && !pan_s2) next_state = S_DISARMED;
         end
         default: next_state = S_DISARMED;
      endcase

      state_chg = (next_state != state);

      // The counter is only ever non-zero in a timed state, so no state qualifier is needed
      if (state_chg) begin
         case (next_state)
            S_EXIT_DELAY:  next_cnt = EXIT_LOAD;
            S_ENTRY_DELAY: next_cnt = ENTRY_LOAD;
            S_ALARM:       next_cnt = ALARM_LOAD;
            default:       next_cnt = '0;
         endcase
      end else if (tick && (cnt != '0)) begin
         next_cnt = cnt - 1'b1;
      end
   end

   // Moore outputs decoded from the state and counter registers
   always_comb begin
      state_out = state;
      armed_led = shows_armed(state);
      countdown = cnt;
`ifdef SIREN_TIMEOUT_EN
      siren     = (state == S_ALARM) && (cnt != '0);
`else
      siren     = (state == S_ALARM);
`endif
   end

endmodule
